// File: rtl/sliced_alu_pkg.sv
// Shared encodings for the bit-sliced sequential ALU: operation codes and FSM states.
package sliced_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_PASSA = 3'd6,
    OP_NOTA  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational S-bit ALU slice. It ripples the carry through the slice and also
// exposes the carry into the slice MSB so that the top level can derive overflow.
module alu_slice
  import sliced_alu_pkg::*;
#(
  parameter int S = 4
) (
  input  logic [S-1:0] a_s,
  input  logic [S-1:0] b_s,
  input  logic         cin,
  input  logic [2:0]   op,
  output logic [S-1:0] f_s,
  output logic         cout_s,
  output logic         c_msb_in
);

  op_e          op_q;
  logic [S-1:0] b_eff;
  logic [S-1:0] sum;
  logic         c;
  logic         c_at_msb;

  assign op_q = op_e'(op);

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    b_eff    = (op_q == OP_SUB) ? ~b_s : b_s;
    sum      = '0;
    c        = cin;
    c_at_msb = 1'b0;
    for (int i = 0; i < S; i++) begin
      if (i == S - 1) c_at_msb = c;
      sum[i] = a_s[i] ^ b_eff[i] ^ c;
      c      = (a_s[i] & b_eff[i]) | (c & (a_s[i] ^ b_eff[i]));
    end
  end

  always_comb begin
    f_s      = '0;
    cout_s   = 1'b0;
    c_msb_in = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        f_s      = sum;
        cout_s   = c;
        c_msb_in = c_at_msb;
      end
      OP_AND:   f_s = a_s & b_s;
      OP_OR:    f_s = a_s | b_s;
      OP_XOR:   f_s = a_s ^ b_s;
      OP_XNOR:  f_s = a_s ^ b_s ^ {S{1'b1}};
      OP_PASSA: f_s = a_s;
      OP_NOTA:  f_s = ~a_s;
      default:  f_s = '0;
    endcase
  end

endmodule

// File: rtl/sliced_alu_seq.sv
// Multi-cycle W-bit ALU that processes one S-bit slice per clock, LSB slice first,
// carrying a single registered bit between slices.
module sliced_alu_seq
  import sliced_alu_pkg::*;
#(
  parameter int W = 16,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] f,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NSLICE = W / S;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e         state, state_next;
  logic [KW-1:0]  k;
  logic           carry;
  logic [W-1:0]   a_q, b_q;
  op_e            op_q;
  logic           accept, last;
  logic [S-1:0]   f_s;
  logic           cout_s, c_msb_in;
  logic [W-1:0]   f_next;

  assign busy   = (state == ST_RUN);
  assign accept = ~busy & start;
  assign last   = (k == KW'(NSLICE - 1));

  alu_slice #(.S(S)) u_slice (
    .a_s      (a_q[int'(k)*S +: S]),
    .b_s      (b_q[int'(k)*S +: S]),
    .cin      (carry),
    .op       (op_q),
    .f_s      (f_s),
    .cout_s   (cout_s),
    .c_msb_in (c_msb_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The full result including the slice being written, so zero sees the final word.
  always_comb begin
    f_next = f;
    f_next[int'(k)*S +: S] = f_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      f     <= '0;
      done  <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op_e'(op);
        k     <= '0;
        carry <= (op_e'(op) == OP_SUB);
        f     <= '0;
      end else if (busy) begin
        f     <= f_next;
        carry <= is_arith(op_q) ? cout_s : 1'b0;
        k     <= last ? '0 : k + 1'b1;
        if (last) begin
          done <= 1'b1;
          cout <= cout_s;
          ovf  <= c_msb_in ^ cout_s;
          zero <= (f_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sliced_alu_seq.sv
// Directed bench for sliced_alu_seq (W=16, S=4) with hand-computed expected results.
module tb_sliced_alu_seq;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] f;

  int n_checks = 0;
  int n_pass   = 0;

  sliced_alu_seq #(.W(W), .S(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Called at a negedge; the accepting posedge falls inside this task.
  task automatic start_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_fclr"}, 32'(f), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ef,
                              input logic ec, input logic eo, input logic ez);
    check({tag, "_f"},    32'(f),    32'(ef));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ef, input logic ec, input logic eo, input logic ez);
    start_op(tag, o, av, bv);
    wait_done(tag, 4);
    check_result(tag, ef, ec, eo, ez);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"},  32'(f),    32'(ef));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_f",    32'(f),    32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add1",  3'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("sub0",  3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("subov", 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("addov", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("addz",  3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("pass",  3'd6, 16'h5A3C, 16'hFFFF, 16'h5A3C, 1'b0, 1'b0, 1'b0);
    run_op("nota",  3'd7, 16'h5A3C, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b0);

    // XNOR with an ignored start two cycles in, then a back-to-back AND.
    start_op("xnor", 3'd5, 16'hF0F0, 16'hFF00);
    @(negedge clk);
    op = 3'd0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("xnor", 2);
    check_result("xnor", 16'hF00F, 1'b0, 1'b0, 1'b0);
    start_op("b2b", 3'd2, 16'hAAAA, 16'h0FF0);
    wait_done("b2b", 4);
    check_result("b2b", 16'h0AA0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset during slice 2 of an ADD: 0x1111 + 0x1111, two slices written so far.
    start_op("abort", 3'd0, 16'h1111, 16'h1111);
    repeat (2) @(negedge clk);
    check("abort_partial", 32'(f), 32'h0022);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_f",    32'(f),    32'd0);
    begin
      logic saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i == 2) rst_n = 1'b1;
        if (done) saw_done = 1'b1;
      end
      check("abort_nodone", 32'(saw_done), 32'd0);
    end
    run_op("post", 3'd0, 16'h0101, 16'h00FF, 16'h0200, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
